// File: rtl/prim_sky130_ram_1p_req_adapter.sv
// ============================================================================
// Module   : prim_sky130_ram_1p_req_adapter
// Brief    : Valid/ready request adapter for a single-port RAM with fixed
//            one-cycle read latency and an in-order response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prim_sky130_ram_1p_req_adapter #(
  parameter int Width    = 32,
  parameter int Depth    = 512,
  parameter int RspDepth = 2,
  localparam int Aw      = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [Aw-1:0]    req_addr_i,
  input  logic [Width-1:0] req_wdata_i,
  input  logic [Width-1:0] req_wmask_i,

  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_rdata_o,
  output logic             rsp_write_o,
  output logic             rsp_err_o,

  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  localparam int PtrW = $clog2(RspDepth);
  localparam int CntW = $clog2(RspDepth + 1);
  localparam logic [CntW:0]   RSP_DEPTH_W = (CntW + 1)'(RspDepth);
  localparam logic [CntW-1:0] RSP_FULL    = CntW'(RspDepth);
  localparam logic [PtrW-1:0] PTR_LAST    = PtrW'(RspDepth - 1);
  localparam logic [Aw:0]     DEPTH_W     = (Aw + 1)'(Depth);

  typedef struct packed {
    logic             write;
    logic             err;
    logic [Width-1:0] data;
  } rsp_t;

  rsp_t            mem_q [RspDepth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            inflight_q, write_q, err_q;

  logic            accept, in_range, fifo_empty, push, pop;
  logic [CntW:0]   occupancy;
  rsp_t            live_rsp, head_rsp;

  // Occupancy counts every accepted-but-unconsumed response, so ready never
  // lets the FIFO overflow and depends only on registered state.
  assign occupancy   = {1'b0, count_q} + (CntW + 1)'(inflight_q);
  assign req_ready_o = !rst_i && (occupancy < RSP_DEPTH_W);
  assign accept      = req_valid_i && req_ready_o;
  assign in_range    = {1'b0, req_addr_i} < DEPTH_W;

  assign ram_req_o   = accept && in_range;
  assign ram_write_o = req_write_i;
  assign ram_addr_o  = req_addr_i;
  assign ram_wdata_o = req_wdata_i;
  assign ram_wmask_o = req_wmask_i;

  assign live_rsp.write = write_q;
  assign live_rsp.err   = err_q;
  assign live_rsp.data  = (write_q || err_q) ? '0 : ram_rdata_i;
  assign head_rsp       = mem_q[rptr_q];

  assign fifo_empty  = (count_q == '0);
  assign rsp_valid_o = !rst_i && (!fifo_empty || inflight_q);
  assign rsp_rdata_o = fifo_empty ? live_rsp.data  : head_rsp.data;
  assign rsp_write_o = fifo_empty ? live_rsp.write : head_rsp.write;
  assign rsp_err_o   = fifo_empty ? live_rsp.err   : head_rsp.err;

  // A fall-through response consumed in its own cycle never enters the FIFO.
  assign pop  = !fifo_empty && rsp_valid_o && rsp_ready_i;
  assign push = inflight_q && (!fifo_empty || !rsp_ready_i);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      inflight_q <= accept;
      write_q    <= req_write_i;
      err_q      <= !in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem_q[wptr_q] <= live_rsp;
  end

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
                                   !(push && (count_q == RSP_FULL)));

endmodule

`default_nettype wire

// File: tb/tb_prim_sky130_ram_1p_req_adapter.sv
// ============================================================================
// Module   : tb_prim_sky130_ram_1p_req_adapter
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            against a queue-based response model and shadow memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prim_sky130_ram_1p_req_adapter;

  localparam int W     = 32;
  localparam int DEPTH = 500;
  localparam int RSPD  = 2;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata, req_wmask;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [W-1:0]  rsp_rdata;
  logic          ram_req, ram_write;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata, ram_wmask, ram_rdata;

  prim_sky130_ram_1p_req_adapter #(.Width(W), .Depth(DEPTH), .RspDepth(RSPD)) u_dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_wmask_i (req_wmask),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_write_o (rsp_write),
    .rsp_err_o   (rsp_err),
    .ram_req_o   (ram_req),
    .ram_write_o (ram_write),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_wmask_o (ram_wmask),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical RAM: one-cycle read latency, garbage on the bus otherwise.
  logic [W-1:0] ram_mem [1 << AW];
  always @(posedge clk) begin
    if (ram_req && ram_write) begin
      ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      ram_rdata         <= $urandom;
    end else if (ram_req) begin
      ram_rdata <= ram_mem[ram_addr];
    end else begin
      ram_rdata <= $urandom;
    end
  end

  typedef struct {
    logic         w;
    logic         e;
    logic [W-1:0] d;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] shadow [1 << AW];
  int           total = 0;
  int           bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check at negedge, advance the model, then clock.
  task automatic cycle(input logic r, input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic [W-1:0] m, input logic rr);
    logic exp_rdy, acc, inr;
    exp_t e;
    rst = r; req_valid = v; req_write = w; req_addr = a;
    req_wdata = d; req_wmask = m; rsp_ready = rr;
    @(negedge clk);
    if (r) begin
      check_val("rst_req_ready", 64'(req_ready), 64'(0));
      check_val("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_val("rst_ram_req",   64'(ram_req),   64'(0));
      exp_q.delete();
    end else begin
      exp_rdy = exp_q.size() < RSPD;
      check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
      check_val("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check_val("rsp_rdata", 64'(rsp_rdata), 64'(exp_q[0].d));
        check_val("rsp_write", 64'(rsp_write), 64'(exp_q[0].w));
        check_val("rsp_err",   64'(rsp_err),   64'(exp_q[0].e));
        if (rr) void'(exp_q.pop_front());
      end
      acc = v && exp_rdy;
      inr = int'(a) < DEPTH;
      check_val("ram_req", 64'(ram_req), 64'(acc && inr));
      if (acc && inr) begin
        check_val("ram_write", 64'(ram_write), 64'(w));
        check_val("ram_addr",  64'(ram_addr),  64'(a));
        if (w) begin
          check_val("ram_wdata", 64'(ram_wdata), 64'(d));
          check_val("ram_wmask", 64'(ram_wmask), 64'(m));
        end
      end
      if (acc) begin
        e.w = w;
        e.e = !inr;
        e.d = '0;
        if (inr && w) shadow[a] = (shadow[a] & ~m) | (d & m);
        else if (inr) e.d = shadow[a];
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = '0;
      shadow[i]  = '0;
    end
    ram_rdata = '0;
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 1);

    // Full-mask write then read back.
    cycle(0, 1, 1, 5, 32'hDEADBEEF, 32'hFFFFFFFF, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 0, 5, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check_val("deadbeef_shadow", 64'(shadow[5]), 64'h0000_0000_DEAD_BEEF);

    // Back-to-back reads.
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, AW'(i), 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Back-pressure: only RSPD accepted, then drain.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, AW'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1);

    // Out-of-range read.
    cycle(0, 1, 0, AW'(510), 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // Reset right after accepting a read.
    cycle(0, 1, 0, 5, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1);

    // Partial mask merge.
    cycle(0, 1, 1, 10, 32'hAAAAAAAA, 32'hFFFFFFFF, 1);
    cycle(0, 1, 1, 10, 32'h12345678, 32'h0000FFFF, 1);
    cycle(0, 1, 0, 10, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check_val("partial_mask_shadow", 64'(shadow[10]), 64'h0000_0000_AAAA_5678);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] m;
      m = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : W'($urandom);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
            AW'($urandom_range(0, (1 << AW) - 1)), W'($urandom), m,
            $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prim_sky130_ram_1p_req_adapter.md
PRIM_SKY130_RAM_1P_REQ_ADAPTER -- requirements
Module: prim_sky130_ram_1p_req_adapter

Interface
REQ-001 SHALL have parameter Width, default 32, data and mask width in bits.
REQ-002 SHALL have parameter Depth, default 512, number of RAM words; Aw = $clog2(Depth).
REQ-003 SHALL have parameter RspDepth, default 2, response FIFO entries; legal values are 2..8.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports req_valid_i, input, 1, and req_ready_o, output, 1, forming the request handshake.
REQ-007 SHALL have port req_write_i, input, 1, where 1 = write and 0 = read.
REQ-008 SHALL have ports req_addr_i (input, Aw), req_wdata_i (input, Width) and req_wmask_i (input, Width, bitwise write enable).
REQ-009 SHALL have ports rsp_valid_o, output, 1, and rsp_ready_i, input, 1, forming the response handshake.
REQ-010 SHALL have ports rsp_rdata_o (output, Width), rsp_write_o (output, 1, response belongs to a write) and rsp_err_o (output, 1, address out of range).
REQ-011 SHALL have RAM-side ports ram_req_o, ram_write_o (output, 1 each), ram_addr_o (output, Aw), and ram_wdata_o, ram_wmask_o (output, Width each).
REQ-012 SHALL have port ram_rdata_i, input, Width, valid exactly one cycle after ram_req_o.

Function
REQ-013 Acceptance SHALL occur in a cycle where req_valid_i and req_ready_o are both 1.
REQ-014 req_ready_o SHALL be 1 iff fifo_count + inflight_q < RspDepth, computed from registered state only and independent of req_valid_i and rsp_ready_i.
REQ-015 For an accepted request with req_addr_i < Depth, ram_req_o SHALL be 1 in the same cycle (zero added latency).
REQ-016 In that case ram_write_o, ram_addr_o, ram_wdata_o and ram_wmask_o SHALL equal the req_* fields, combinationally.
REQ-017 ram_req_o SHALL be 0 otherwise, including for an accepted request with req_addr_i >= Depth (only possible when Depth is not a power of 2).
REQ-018 Every accepted request SHALL produce exactly one response, and responses SHALL be returned in acceptance order.
REQ-019 inflight_q SHALL be set to 1 in cycle T+1 after acceptance in cycle T, together with registered write/err tags; it SHALL be cleared otherwise.
REQ-020 Response data at T+1 SHALL be ram_rdata_i for an in-range read, and 0 for a write or an out-of-range access.
REQ-021 rsp_err_o SHALL be 1 only for out-of-range accesses; rsp_write_o SHALL mirror the original req_write_i.
REQ-022 Fall-through: if the FIFO is empty and inflight_q = 1, then rsp_valid_o = 1 and the rsp_* outputs SHALL equal the T+1 response.
REQ-023 In the fall-through case, if rsp_ready_i = 1 the response SHALL be consumed and not stored; otherwise it SHALL be pushed into the FIFO.
REQ-024 If the FIFO is non-empty, rsp_* SHALL present the FIFO head, any inflight response SHALL be pushed at the tail, and a pop SHALL occur when rsp_valid_o and rsp_ready_i are both 1.
REQ-025 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve order.
REQ-026 The FIFO SHALL never overflow; with REQ-014 this requires no extra check, but an assertion SHALL flag a push when full.
REQ-027 Pointers SHALL wrap modulo RspDepth.
REQ-028 With rsp_ready_i held at 1, the block SHALL sustain one request per cycle, with each response at T+1.
REQ-029 rsp_valid_o SHALL be 0 when the FIFO is empty and inflight_q = 0.
REQ-030 rsp_rdata_o SHALL be held stable while rsp_valid_o = 1 and rsp_ready_i = 0.

Reset
REQ-031 While rst_i = 1: fifo_count, pointers and inflight_q SHALL be 0.
REQ-032 While rst_i = 1: rsp_valid_o SHALL be 0, req_ready_o SHALL be 0 and ram_req_o SHALL be 0.
REQ-033 In the first cycle after rst_i deasserts, req_ready_o SHALL be 1.
REQ-034 Reset asserted mid-operation SHALL discard all buffered and in-flight responses, with no response emitted afterward for pre-reset requests.

Verification
REQ-035 Write 0xDEADBEEF to address 5 with full mask, then read address 5, rsp_ready_i = 1: write response at T+1 has rsp_write_o = 1 and rdata 0; read response at T+3 (read accepted T+2) returns 0xDEADBEEF.
REQ-036 Back-to-back reads of addresses 0..7, rsp_ready_i = 1: req_ready_o stays 1; responses are contiguous, in order, each one cycle after its request.
REQ-037 rsp_ready_i = 0 with continuous requests: exactly RspDepth (2) requests accepted; req_ready_o then stays 0; raising rsp_ready_i drains both in order and ready reasserts.
REQ-038 Depth = 500, read address 510: ram_req_o stays 0; response has rsp_err_o = 1 and rdata 0.
REQ-039 Assert rst_i the cycle after accepting a read: no response appears after reset; req_ready_o = 1 in the first post-reset cycle.
REQ-040 Partial mask 0x0000FFFF writing 0x12345678 over 0xAAAAAAAA: subsequent read returns 0xAAAA5678.
